// File: rtl/vector_alu_seq.sv
// Multi-lane sequential ALU: LANES independent WIDTH-bit lanes sharing one opcode.
// ADD/SUB/MUL finish in one cycle; DIV is a radix-2 restoring divider, all lanes in lockstep.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | ready for a new operation (in_ready=1)
// S_DIV  | iterating the divider, one quotient bit per cycle
// S_DONE | result presented on out/flags/div0, waiting for out_ready
module vector_alu_seq #(
   parameter int WIDTH = 32,
   parameter int LANES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in0,
   input  logic [LANES*WIDTH-1:0]   in1,
   input  logic [1:0]               op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   out,
   output logic [2*LANES-1:0]       flags,
   output logic [LANES-1:0]         div0,
   output logic                     busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic                     out_valid_q, out_valid_d;
   logic [LANES*WIDTH-1:0]   out_q, out_d;
   logic [2*LANES-1:0]       flags_q, flags_d;
   logic [LANES-1:0]         div0_q, div0_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [LANES*WIDTH-1:0]   rem_q, rem_d;
   logic [LANES*WIDTH-1:0]   quo_q, quo_d;
   logic [LANES*WIDTH-1:0]   dvs_q, dvs_d;

   logic [LANES-1:0][WIDTH:0] part;
   logic [LANES-1:0]          q_bit;
   logic [LANES*WIDTH-1:0]    step_rem;
   logic [LANES*WIDTH-1:0]    step_quo;

   // Z/N per lane, taken from the value that is about to be registered as the result.
   function automatic logic [2*LANES-1:0] flags_of(input logic [LANES*WIDTH-1:0] v);
      logic [2*LANES-1:0] f;
      f = '0;
      for (int i = 0; i < LANES; i++) begin
         f[2*i+1] = ~|v[i*WIDTH +: WIDTH];
         f[2*i]   = v[i*WIDTH + WIDTH - 1];
      end
      return f;
   endfunction

   // Single-cycle lane arithmetic; DIV never reaches here.
   function automatic logic [LANES*WIDTH-1:0] alu_of(input logic [1:0] o,
                                                     input logic [LANES*WIDTH-1:0] a,
                                                     input logic [LANES*WIDTH-1:0] b);
      logic [LANES*WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         case (o)
            OP_ADD:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
            OP_SUB:  r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] - b[i*WIDTH +: WIDTH];
            default: r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] * b[i*WIDTH +: WIDTH];
         endcase
      end
      return r;
   endfunction

   // One restoring-division step per lane. A zero divisor always "fits", so the
   // quotient naturally saturates to all ones without a special case.
   always_comb begin
      part     = '0;
      q_bit    = '0;
      step_rem = '0;
      step_quo = '0;
      for (int i = 0; i < LANES; i++) begin
         part[i]  = {rem_q[i*WIDTH +: WIDTH], quo_q[i*WIDTH + WIDTH - 1]};
         q_bit[i] = (part[i] >= {1'b0, dvs_q[i*WIDTH +: WIDTH]});
         step_rem[i*WIDTH +: WIDTH] = q_bit[i]
            ? WIDTH'(part[i] - {1'b0, dvs_q[i*WIDTH +: WIDTH]})
            : part[i][WIDTH-1:0];
         step_quo[i*WIDTH +: WIDTH] = {quo_q[i*WIDTH +: WIDTH-1], q_bit[i]};
      end
   end

   // Next-state and result logic for the accept / divide / handshake sequence.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      flags_d     = flags_q;
      div0_d      = div0_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (op == OP_DIV) begin
                  rem_d   = '0;
                  quo_d   = in0;
                  dvs_d   = in1;
                  cnt_d   = CW'(WIDTH);
                  state_d = S_DIV;
               end else begin
                  out_d       = alu_of(op, in0, in1);
                  flags_d     = flags_of(out_d);
                  div0_d      = '0;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DIV: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               out_d   = step_quo;
               flags_d = flags_of(step_quo);
               for (int i = 0; i < LANES; i++) begin
                  div0_d[i] = (dvs_q[i*WIDTH +: WIDTH] == '0);
               end
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         flags_q     <= '0;
         div0_q      <= '0;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         flags_q     <= flags_d;
         div0_q      <= div0_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign flags     = flags_q;
   assign div0      = div0_q;

endmodule
